ddram_clear_check: RTL and testbench
====================================

Name: ddram_clear_check

Overview:
- Read-back companion to the menu core's SDRAM/DDR3 clear writer.
- Walks a DDR3 window with bursting reads on the DDRAM_* interface and compares every 64-bit beat against an expected pattern (zero after a clear).
- Reports the error count and the first failing address.
- Sits beside the ddram writer in emu; the two share the DDRAM port through an external mux (out of scope for this block).

Parameters:
- BURST, 128: maximum beats per read request; legal range 1..128.
- START_ADDR, 29'd0: first 64-bit word address read.
- WORDS, 29'd4194304: number of 64-bit words checked (32 MB); must be at least 1.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a check pass when idle.
- pattern  in  64  expected beat value; sampled on the accepted start.
- busy  out  1  high from the accepted start until the pass completes.
- done  out  1  high after a pass completes; held until the next accepted start or reset.
- err_count  out  16  number of mismatching beats; saturates at 16'hFFFF.
- first_err_addr  out  29  word address of the first mismatch; valid when err_count != 0.
- DDRAM_BUSY  in  1  slave waitrequest.
- DDRAM_BURSTCNT  out  8  beats in the current request.
- DDRAM_ADDR  out  29  burst base word address.
- DDRAM_RD  out  1  read request.
- DDRAM_DOUT  in  64  read data.
- DDRAM_DOUT_READY  in  1  read data valid.
- DDRAM_DIN  out  64  tied to 0.
- DDRAM_BE  out  8  tied to 8'hFF.
- DDRAM_WE  out  1  tied to 0.

Behaviour:
- Reset values: busy=0, done=0, err_count=0, first_err_addr=0, DDRAM_RD=0, DDRAM_ADDR=START_ADDR, DDRAM_BURSTCNT=0, state=IDLE.
- A reset asserted mid-pass takes effect on the next edge: RD drops, all counters clear, no done pulse is produced.
- FSM states: IDLE, REQ, DATA, FIN.
- IDLE:
  - start=1 latches pattern, clears err_count and first_err_addr, and sets remaining=WORDS and addr=START_ADDR.
  - Sets busy=1 and done=0, then goes to REQ.
  - start is ignored in every other state.
- REQ:
  - Drive RD=1, DDRAM_ADDR=addr, DDRAM_BURSTCNT=len, where len = min(BURST, remaining).
  - ADDR and BURSTCNT stay stable while BUSY=1.
  - The request is accepted on the edge where RD=1 and BUSY=0. RD then drops on the next cycle and the FSM goes to DATA with beat=0.
  - Exactly one accepted request is outstanding at any time.
- DATA:
  - Each DOUT_READY=1 cycle is one beat. If DOUT != pattern, err_count increments (saturating).
  - If err_count was 0 before that beat, first_err_addr = addr + beat (29-bit wrap).
  - beat increments on every beat.
  - On the beat where beat == len-1: addr += len, remaining -= len.
  - If the new remaining is 0, go to FIN; otherwise go to REQ.
  - A beat and the REQ transition in the same cycle are fine: the next request asserts RD on the following cycle.
- FIN: busy=0, done=1; go to IDLE in the same cycle.
- DOUT_READY seen in IDLE, REQ or FIN (for example, stray beats after a reset mid-burst) is ignored and does not change counters.
- Address arithmetic is 29-bit modulo. A window crossing 29'h1FFFFFFF wraps to 0.
- A short final burst (remaining < BURST) uses BURSTCNT = remaining.
- Total requests per pass = ceil(WORDS / BURST).
- No timeout: a DDRAM that never returns data keeps busy=1 until reset.

Decomposition:
- Package ddram_chk_pkg holds:
  - state enum {IDLE, REQ, DATA, FIN};
  - localparam DDR_AW = 29;
  - localparam DDR_DW = 64;
  - the saturation constant 16'hFFFF.
- No sub-module. Optional reuse: a 64-bit compare is inline; the model pairs this block with the existing ddram writer in testbenches.

Test Plan:
- Clean pass. WORDS=300, BURST=128, pattern=0, memory model all zero.
  - Required: requests at addresses 0, 128, 256 with BURSTCNT 128, 128, 44.
  - Required: done=1, err_count=0, busy high for the whole pass.
- Single error. Memory word 200 = 64'h1, otherwise as the clean pass.
  - Required: err_count=1, first_err_addr=200.
- Waitrequest. Hold BUSY=1 for 5 cycles on every request.
  - Required: RD, ADDR and BURSTCNT stay constant while BUSY=1.
  - Required: exactly 3 accepted requests and a correct final result.
- Saturation. WORDS=70000, pattern=64'hFFFF_FFFF_FFFF_FFFF, memory all zero.
  - Required: err_count=16'hFFFF, first_err_addr=START_ADDR.
- Reset mid-burst. Assert reset after 10 beats of the first burst while the model still emits 118 beats.
  - Required: all outputs at reset values and stray beats ignored.
  - Required: a following start completes normally with err_count=0.
- Start while busy, plus wrap. Pulse start during DATA with START_ADDR=29'h1FFFFFF0 and WORDS=32.
  - Required: the extra start is ignored.
  - Required: requests go to 29'h1FFFFFF0 (BURSTCNT 32), and the first error injected at model word 29'h00000003 reports first_err_addr=3.

Source files
------------

// File: rtl/ddram_clear_check_pkg.sv
// ddram_chk_pkg
//   Shared definitions for the DDR3 clear read-back checker:
//   FSM state type, DDRAM bus widths, error-counter saturation value
//   and the burst length helper used when issuing read requests.
package ddram_chk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DATA,
        FIN
    } state_t;

    localparam int DDR_AW = 29;
    localparam int DDR_DW = 64;

    localparam logic [15:0] ERR_SAT = 16'hFFFF;

    // Beats for the next request: min(burst, remaining). burst is at most 128.
    function automatic logic [7:0] burst_len(input logic [DDR_AW-1:0] remaining,
                                             input int unsigned       burst);
        logic [31:0] rem32;
        rem32 = {3'b000, remaining};
        if (rem32 < burst) begin
            return remaining[7:0];
        end
        return burst[7:0];
    endfunction

endpackage

// File: rtl/ddram_clear_check.sv
// ddram_clear_check
//   Walks a DDR3 window with bursting reads and compares every 64-bit beat
//   against an expected pattern (zero after a clear). Reports the number of
//   mismatching beats (saturating) and the word address of the first one.
//
// Ports
//   clk_sys, reset         : system clock, synchronous active-high reset
//   start, pattern         : start pulse (accepted when idle), expected beat
//   busy, done             : pass in progress / pass finished (held)
//   err_count              : mismatching beats, saturates at 16'hFFFF
//   first_err_addr         : word address of first mismatch
//   DDRAM_*                : read-only master on the DDRAM bus; write side tied off
module ddram_clear_check
    import ddram_chk_pkg::*;
#(
    parameter int unsigned         BURST      = 128,
    parameter logic [DDR_AW-1:0]   START_ADDR = 29'd0,
    parameter logic [DDR_AW-1:0]   WORDS      = 29'd4194304
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                start,
    input  logic [DDR_DW-1:0]   pattern,
    output logic                busy,
    output logic                done,
    output logic [15:0]         err_count,
    output logic [DDR_AW-1:0]   first_err_addr,
    input  logic                DDRAM_BUSY,
    output logic [7:0]          DDRAM_BURSTCNT,
    output logic [DDR_AW-1:0]   DDRAM_ADDR,
    output logic                DDRAM_RD,
    input  logic [DDR_DW-1:0]   DDRAM_DOUT,
    input  logic                DDRAM_DOUT_READY,
    output logic [DDR_DW-1:0]   DDRAM_DIN,
    output logic [7:0]          DDRAM_BE,
    output logic                DDRAM_WE
);

    state_t              r_state;
    logic [DDR_DW-1:0]   r_pattern;
    logic [DDR_AW-1:0]   r_addr;
    logic [DDR_AW-1:0]   r_remaining;
    logic [7:0]          r_len;
    logic [7:0]          r_beat;
    logic [15:0]         r_err;
    logic [DDR_AW-1:0]   r_first;
    logic                r_busy;
    logic                r_done;
    logic                r_rd;
    logic [DDR_AW-1:0]   r_ddr_addr;
    logic [7:0]          r_burstcnt;

    logic [7:0]          w_len_start;
    logic [DDR_AW-1:0]   w_addr_next;
    logic [DDR_AW-1:0]   w_rem_next;
    logic [7:0]          w_len_next;
    logic [DDR_AW-1:0]   w_beat_addr;
    logic                w_mismatch;
    logic                w_last;

    always_comb begin
        w_len_start = burst_len(WORDS, BURST);
        w_addr_next = r_addr + {21'd0, r_len};
        w_rem_next  = r_remaining - {21'd0, r_len};
        w_len_next  = burst_len(w_rem_next, BURST);
        w_beat_addr = r_addr + {21'd0, r_beat};
        w_mismatch  = (DDRAM_DOUT != r_pattern);
        w_last      = (r_beat == r_len - 8'd1);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state     <= IDLE;
            r_pattern   <= '0;
            r_addr      <= START_ADDR;
            r_remaining <= '0;
            r_len       <= '0;
            r_beat      <= '0;
            r_err       <= '0;
            r_first     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rd        <= 1'b0;
            r_ddr_addr  <= START_ADDR;
            r_burstcnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_pattern   <= pattern;
                        r_err       <= '0;
                        r_first     <= '0;
                        r_remaining <= WORDS;
                        r_addr      <= START_ADDR;
                        r_len       <= w_len_start;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        // Request outputs are registered, so they are loaded
                        // on entry to REQ rather than inside it.
                        r_rd        <= 1'b1;
                        r_ddr_addr  <= START_ADDR;
                        r_burstcnt  <= w_len_start;
                        r_state     <= REQ;
                    end
                end
                REQ: begin
                    if (!DDRAM_BUSY) begin
                        r_rd    <= 1'b0;
                        r_beat  <= '0;
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (DDRAM_DOUT_READY) begin
                        if (w_mismatch) begin
                            if (r_err != ERR_SAT) begin
                                r_err <= r_err + 16'd1;
                            end
                            if (r_err == '0) begin
                                r_first <= w_beat_addr;
                            end
                        end
                        r_beat <= r_beat + 8'd1;
                        if (w_last) begin
                            r_addr      <= w_addr_next;
                            r_remaining <= w_rem_next;
                            if (w_rem_next == '0) begin
                                // busy/done are set on entry so they are
                                // already visible while in FIN.
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= FIN;
                            end else begin
                                r_len      <= w_len_next;
                                r_rd       <= 1'b1;
                                r_ddr_addr <= w_addr_next;
                                r_burstcnt <= w_len_next;
                                r_state    <= REQ;
                            end
                        end
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign err_count      = r_err;
    assign first_err_addr = r_first;
    assign DDRAM_RD       = r_rd;
    assign DDRAM_ADDR     = r_ddr_addr;
    assign DDRAM_BURSTCNT = r_burstcnt;
    assign DDRAM_DIN      = '0;
    assign DDRAM_BE       = '1;
    assign DDRAM_WE       = 1'b0;

endmodule

// File: tb/tb_ddram_clear_check.sv
// tb_ddram_clear_check
//   Three checker instances (300-word window at 0, 70000-word window at 0,
//   32-word window wrapping from 29'h1FFFFFF0) against a behavioural DDRAM
//   model with configurable waitrequest length and random data gaps.
module tb_ddram_clear_check;

    localparam logic [28:0] WRAP_BASE = 29'h1FFFFFF0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst;
    logic [2:0]  st;
    logic [2:0]  busy, done, rd, we;
    logic [2:0]  dbusy = '0;
    logic [2:0]  drdy  = '0;
    logic [63:0] pat  [3];
    logic [63:0] dout [3];
    logic [63:0] din  [3];
    logic [15:0] errc [3];
    logic [28:0] ferr [3];
    logic [28:0] daddr[3];
    logic [7:0]  bcnt [3];
    logic [7:0]  be   [3];

    ddram_clear_check #(.BURST(128), .START_ADDR(29'd0), .WORDS(29'd300)) u_dut0 (
        .clk_sys(clk), .reset(rst[0]), .start(st[0]), .pattern(pat[0]),
        .busy(busy[0]), .done(done[0]), .err_count(errc[0]), .first_err_addr(ferr[0]),
        .DDRAM_BUSY(dbusy[0]), .DDRAM_BURSTCNT(bcnt[0]), .DDRAM_ADDR(daddr[0]),
        .DDRAM_RD(rd[0]), .DDRAM_DOUT(dout[0]), .DDRAM_DOUT_READY(drdy[0]),
        .DDRAM_DIN(din[0]), .DDRAM_BE(be[0]), .DDRAM_WE(we[0]));

    ddram_clear_check #(.BURST(128), .START_ADDR(29'd0), .WORDS(29'd70000)) u_dut1 (
        .clk_sys(clk), .reset(rst[1]), .start(st[1]), .pattern(pat[1]),
        .busy(busy[1]), .done(done[1]), .err_count(errc[1]), .first_err_addr(ferr[1]),
        .DDRAM_BUSY(dbusy[1]), .DDRAM_BURSTCNT(bcnt[1]), .DDRAM_ADDR(daddr[1]),
        .DDRAM_RD(rd[1]), .DDRAM_DOUT(dout[1]), .DDRAM_DOUT_READY(drdy[1]),
        .DDRAM_DIN(din[1]), .DDRAM_BE(be[1]), .DDRAM_WE(we[1]));

    ddram_clear_check #(.BURST(128), .START_ADDR(WRAP_BASE), .WORDS(29'd32)) u_dut2 (
        .clk_sys(clk), .reset(rst[2]), .start(st[2]), .pattern(pat[2]),
        .busy(busy[2]), .done(done[2]), .err_count(errc[2]), .first_err_addr(ferr[2]),
        .DDRAM_BUSY(dbusy[2]), .DDRAM_BURSTCNT(bcnt[2]), .DDRAM_ADDR(daddr[2]),
        .DDRAM_RD(rd[2]), .DDRAM_DOUT(dout[2]), .DDRAM_DOUT_READY(drdy[2]),
        .DDRAM_DIN(din[2]), .DDRAM_BE(be[2]), .DDRAM_WE(we[2]));

    // Memory contents: sparse overrides on top of a per-instance base value.
    logic [63:0] mem0 [logic [28:0]];
    logic [63:0] mem1 [logic [28:0]];
    logic [63:0] mem2 [logic [28:0]];
    logic [63:0] base [3];
    int unsigned hold [3];
    int unsigned gap  [3];
    bit          poison [3];

    // Written only by the DDRAM model process.
    logic [28:0] act_q [3][$];
    logic [28:0] req_a [3][$];
    logic [7:0]  req_c [3][$];
    logic [28:0] pend_a [3];
    int unsigned pend_n [3];
    int unsigned wcnt [3];
    bit          stalled [3];
    logic [28:0] sv_a [3];
    logic [7:0]  sv_c [3];
    int unsigned beats_sent [3];
    int unsigned hold_viol [3];

    int unsigned n_checks = 0;
    int unsigned n_err    = 0;

    function automatic logic [63:0] mem_rd(input int g, input logic [28:0] a);
        case (g)
            0:       return mem0.exists(a) ? mem0[a] : base[0];
            1:       return mem1.exists(a) ? mem1[a] : base[1];
            default: return mem2.exists(a) ? mem2[a] : base[2];
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Behavioural DDRAM slave: waitrequest for hold[g] cycles per request,
    // read data returned starting two cycles after acceptance with random gaps.
    initial begin
        for (int g = 0; g < 3; g++) begin
            pend_n[g] = 0; wcnt[g] = 0; stalled[g] = 0;
            beats_sent[g] = 0; hold_viol[g] = 0; dout[g] = '0;
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (act_q[g].size() != 0 && $urandom_range(99) >= gap[g]) begin
                logic [28:0] a;
                a = act_q[g].pop_front();
                drdy[g] = 1'b1;
                dout[g] = poison[g] ? 64'hDEAD_BEEF_0BAD_F00D : mem_rd(g, a);
                beats_sent[g]++;
            end else begin
                drdy[g] = 1'b0;
                dout[g] = {$urandom, $urandom};
            end
            for (int unsigned k = 0; k < pend_n[g]; k++) begin
                act_q[g].push_back(pend_a[g] + 29'(k));
            end
            pend_n[g] = 0;
            if (rd[g]) begin
                if (stalled[g] && (daddr[g] != sv_a[g] || bcnt[g] != sv_c[g])) begin
                    hold_viol[g]++;
                end
                if (wcnt[g] < hold[g]) begin
                    stalled[g] = 1; sv_a[g] = daddr[g]; sv_c[g] = bcnt[g];
                    wcnt[g]++; dbusy[g] = 1'b1;
                end else begin
                    stalled[g] = 0; wcnt[g] = 0; dbusy[g] = 1'b0;
                    pend_a[g] = daddr[g]; pend_n[g] = bcnt[g];
                    req_a[g].push_back(daddr[g]);
                    req_c[g].push_back(bcnt[g]);
                end
            end else begin
                if (stalled[g] && !rst[g]) hold_viol[g]++;
                stalled[g] = 0; wcnt[g] = 0; dbusy[g] = 1'b0;
            end
        end
    end

    task automatic check_reset_state(input int g, input logic [28:0] sa);
        check_eq("rst_busy",  busy[g],  1'b0);
        check_eq("rst_done",  done[g],  1'b0);
        check_eq("rst_errc",  errc[g],  16'd0);
        check_eq("rst_ferr",  ferr[g],  29'd0);
        check_eq("rst_rd",    rd[g],    1'b0);
        check_eq("rst_addr",  daddr[g], sa);
        check_eq("rst_bcnt",  bcnt[g],  8'd0);
    endtask

    // One full pass on instance g, compared against expectations derived
    // from the window, burst size and memory contents.
    task automatic run_pass(input int g, input logic [63:0] p, input int unsigned words,
                            input logic [28:0] sa, input bit extra_start);
        int unsigned rq0, b0, n, drops, budget, nreq, off, len, exp_err;
        logic [28:0] exp_first;
        bit first_set, pulsed;
        rq0 = req_a[g].size();
        b0  = beats_sent[g];
        @(negedge clk);
        pat[g] = p; st[g] = 1'b1;
        @(negedge clk);
        st[g] = 1'b0; pat[g] = ~p;
        check_eq("busy_start", busy[g], 1'b1);
        n = 0; drops = 0; pulsed = 0;
        budget = words * 2 + 1000;
        while (!done[g] && n < budget) begin
            @(negedge clk);
            n++;
            st[g] = 1'b0;
            if (!done[g] && !busy[g]) drops++;
            if (extra_start && !pulsed && beats_sent[g] >= b0 + 3) begin
                st[g] = 1'b1; pulsed = 1;
            end
        end
        st[g] = 1'b0;
        check_eq("done", done[g], 1'b1);
        check_eq("busy_drop", drops, 0);
        check_eq("busy_end", busy[g], 1'b0);

        nreq = 0; off = 0;
        while (off < words) begin
            len = (words - off < 128) ? words - off : 128;
            if (rq0 + nreq < req_a[g].size()) begin
                check_eq("req_addr", req_a[g][rq0 + nreq], sa + 29'(off));
                check_eq("req_cnt",  req_c[g][rq0 + nreq], len);
            end
            nreq++; off += len;
        end
        check_eq("req_count", req_a[g].size() - rq0, nreq);

        exp_err = 0; exp_first = '0; first_set = 0;
        for (int unsigned i = 0; i < words; i++) begin
            logic [28:0] a;
            a = sa + 29'(i);
            if (mem_rd(g, a) != p) begin
                if (exp_err < 16'hFFFF) exp_err++;
                if (!first_set) begin exp_first = a; first_set = 1; end
            end
        end
        check_eq("err_count", errc[g], exp_err);
        check_eq("first_err", ferr[g], exp_first);
        check_eq("hold_stable", hold_viol[g], 0);
        repeat (3) @(negedge clk);
        check_eq("done_hold", done[g], 1'b1);
    endtask

    initial begin
        rst = '1; st = '0;
        for (int g = 0; g < 3; g++) begin
            pat[g] = '0; base[g] = '0; hold[g] = 0; gap[g] = 0; poison[g] = 0;
        end
        repeat (3) @(negedge clk);
        check_reset_state(0, 29'd0);
        check_reset_state(1, 29'd0);
        check_reset_state(2, WRAP_BASE);
        check_eq("tie_din", din[0], 64'd0);
        check_eq("tie_be",  be[0],  8'hFF);
        check_eq("tie_we",  we[0],  1'b0);
        rst = '0;
        @(negedge clk);

        // Clean pass, then a single error at word 200.
        gap[0] = 25;
        run_pass(0, 64'd0, 300, 29'd0, 0);
        mem0[29'd200] = 64'h1;
        run_pass(0, 64'd0, 300, 29'd0, 0);

        // Waitrequest held for 5 cycles on every request.
        hold[0] = 5;
        run_pass(0, 64'd0, 300, 29'd0, 0);
        hold[0] = 0;

        // Reset after ~10 beats of the first burst; the rest arrive as strays.
        mem0.delete();
        gap[0] = 0;
        begin
            int unsigned b0, n;
            b0 = beats_sent[0];
            @(negedge clk);
            pat[0] = '0; st[0] = 1'b1;
            @(negedge clk);
            st[0] = 1'b0;
            n = 0;
            while (beats_sent[0] < b0 + 10 && n < 500) begin
                @(negedge clk);
                n++;
            end
            check_eq("beats_before_reset", beats_sent[0] >= b0 + 10, 1'b1);
            poison[0] = 1; rst[0] = 1'b1;
            @(negedge clk);
            check_reset_state(0, 29'd0);
            rst[0] = 1'b0;
            n = 0;
            while (act_q[0].size() != 0 && n < 500) begin
                @(negedge clk);
                n++;
            end
            repeat (3) @(negedge clk);
            check_eq("stray_drained", act_q[0].size(), 0);
            check_eq("stray_errc", errc[0], 16'd0);
            check_eq("stray_busy", busy[0], 1'b0);
            check_eq("stray_done", done[0], 1'b0);
            check_eq("stray_rd",   rd[0],   1'b0);
            poison[0] = 0;
        end
        run_pass(0, 64'd0, 300, 29'd0, 0);

        // Randomised passes: random pattern, sparse corrupted words, random
        // waitrequest and data gaps.
        for (int r = 0; r < 4; r++) begin
            logic [63:0] p;
            int unsigned ne;
            p = {$urandom, $urandom};
            base[0] = p;
            mem0.delete();
            ne = $urandom_range(0, 4);
            for (int unsigned k = 0; k < ne; k++) begin
                mem0[29'($urandom_range(0, 299))] = p ^ ({$urandom, $urandom} | 64'd1);
            end
            hold[0] = $urandom_range(0, 3);
            gap[0]  = $urandom_range(0, 50);
            run_pass(0, p, 300, 29'd0, 0);
        end

        // Start ignored during DATA, window wrapping past 29'h1FFFFFFF.
        hold[2] = 2; gap[2] = 30;
        mem2[29'd3] = 64'h1;
        mem2[29'd7] = 64'h2;
        run_pass(2, 64'd0, 32, WRAP_BASE, 1);

        // Saturation: every one of 70000 beats mismatches.
        base[1] = '0; hold[1] = 0; gap[1] = 0;
        run_pass(1, 64'hFFFF_FFFF_FFFF_FFFF, 70000, 29'd0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
